// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Package     : ps2_pkg
// Description : Shared PS/2 receiver types: FSM state encoding, frame widths
//               and the idle bus level used to preset the synchronisers.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    localparam int   PS2_DATA_BITS  = 8;
    localparam logic PS2_IDLE_LEVEL = 1'b1;

endpackage
`default_nettype wire

// File: rtl/ps2_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ps2_rx_fifo
// Description : Small synchronous scancode FIFO with a registered head output.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [PS2_DATA_BITS-1:0] din,
    input  logic                     pop,
    output logic [PS2_DATA_BITS-1:0] dout,
    output logic                     empty,
    output logic                     full
);

    localparam int            AW        = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   DEPTH_CNT = FIFO_DEPTH[AW:0];
    localparam logic [AW:0]   ONE_CNT   = {{AW{1'b0}}, 1'b1};

    logic [PS2_DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [AW:0]              count_q, count_d;
    logic [PS2_DATA_BITS-1:0] dout_q, dout_d;
    logic                     pop_ok;
    logic                     push_ok;

    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_CNT);
    assign dout  = dout_q;

    always_comb begin
        pop_ok   = pop & ~empty;
        push_ok  = push & (~full | pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // A lone surviving entry that is being written right now is the new head.
        if (push_ok && count_d == ONE_CNT) begin
            dout_d = din;
        end else if (count_d != '0) begin
            dout_d = mem_q[rd_ptr_d];
        end else begin
            dout_d = dout_q;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ps2_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ps2_rx_ctrl
// Description : PS/2 receive controller: synchronise, deframe, check, queue.
//               Define PS2_RX_ERRCOUNT_EN to build the saturating error counter.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_rx_ctrl
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2Clk,
    input  logic       ps2Data,
    input  logic       rxRead,
    input  logic       clearErr,
    output logic [7:0] rxData,
    output logic       rxValid,
    output logic       busy,
    output logic       parityErr,
    output logic       frameErr,
    output logic       overflow,
    output logic [7:0] errCount
);

    localparam int                 TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam int                 BIT_W    = $clog2(PS2_DATA_BITS);
    localparam logic [TMR_W-1:0]   TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [BIT_W-1:0]   BIT_LAST = BIT_W'(PS2_DATA_BITS - 1);

    // [0],[1] synchroniser stages, [2] previous sample for edge detection
    logic [2:0]               ck_sync_q;
    logic [1:0]               dt_sync_q;
    logic                     fall;
    logic                     rx_bit;

    ps2_state_e               state_q, state_d;
    logic [BIT_W-1:0]         bit_cnt_q, bit_cnt_d;
    logic [PS2_DATA_BITS-1:0] shift_q, shift_d;
    logic                     parity_q, parity_d;
    logic [TMR_W-1:0]         timer_q, timer_d;

    logic                     push;
    logic                     perr_set;
    logic                     ferr_set;
    logic                     ovf_set;
    logic                     fifo_empty;
    logic                     fifo_full;
    logic                     parity_err_q, frame_err_q, overflow_q;

    assign fall   = ck_sync_q[2] & ~ck_sync_q[1];
    assign rx_bit = dt_sync_q[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ck_sync_q <= {3{PS2_IDLE_LEVEL}};
            dt_sync_q <= {2{PS2_IDLE_LEVEL}};
        end else begin
            ck_sync_q <= {ck_sync_q[1:0], ps2Clk};
            dt_sync_q <= {dt_sync_q[0], ps2Data};
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        timer_d   = (state_q == IDLE) ? '0 : timer_q + 1'b1;
        push      = 1'b0;
        perr_set  = 1'b0;
        ferr_set  = 1'b0;
        if (fall) begin
            timer_d = '0;
            case (state_q)
                IDLE: begin
                    if (!rx_bit) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    shift_d   = {rx_bit, shift_q[PS2_DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BIT_LAST) state_d = PARITY;
                end
                PARITY: begin
                    parity_d = rx_bit;
                    state_d  = STOP;
                end
                STOP: begin
                    // A bad stop bit outranks bad parity.
                    if (!rx_bit)                    ferr_set = 1'b1;
                    else if (^{shift_q, parity_q})  push     = 1'b1;
                    else                            perr_set = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE && timer_q == TMR_LAST) begin
            state_d  = IDLE;
            timer_d  = '0;
            ferr_set = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            timer_q   <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            timer_q   <= timer_d;
        end
    end

    ps2_rx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (shift_q),
        .pop   (rxRead),
        .dout  (rxData),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign ovf_set = push & fifo_full & ~(rxRead & ~fifo_empty);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            if (perr_set)      parity_err_q <= 1'b1;
            else if (clearErr) parity_err_q <= 1'b0;
            if (ferr_set)      frame_err_q  <= 1'b1;
            else if (clearErr) frame_err_q  <= 1'b0;
            if (ovf_set)       overflow_q   <= 1'b1;
            else if (clearErr) overflow_q   <= 1'b0;
        end
    end

`ifdef PS2_RX_ERRCOUNT_EN
    logic       any_set;
    logic [7:0] err_cnt_q, err_cnt_d;

    assign any_set = perr_set | ferr_set | ovf_set;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clearErr)                          err_cnt_d = any_set ? 8'd1 : 8'd0;
        else if (any_set && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_cnt_q <= 8'd0;
        else       err_cnt_q <= err_cnt_d;
    end

    assign errCount = err_cnt_q;
`else
    assign errCount = 8'h00;
`endif

    assign rxValid   = ~fifo_empty;
    assign busy      = (state_q != IDLE);
    assign parityErr = parity_err_q;
    assign frameErr  = frame_err_q;
    assign overflow  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_rx_ctrl
// Description : Self-checking bench for ps2_rx_ctrl against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_rx_ctrl;

    localparam int DEPTH = 4;
    localparam int TO    = 300;
    localparam int H     = 4;    // clk cycles per PS/2 clock half-period

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2Clk;
    logic       ps2Data;
    logic       rxRead;
    logic       clearErr;
    logic [7:0] rxData;
    logic       rxValid;
    logic       busy;
    logic       parityErr;
    logic       frameErr;
    logic       overflow;
    logic [7:0] errCount;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] exp_q [$];
    logic       exp_perr, exp_ferr, exp_ovf;
    int         exp_cnt;

    ps2_rx_ctrl #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2Clk    (ps2Clk),
        .ps2Data   (ps2Data),
        .rxRead    (rxRead),
        .clearErr  (clearErr),
        .rxData    (rxData),
        .rxValid   (rxValid),
        .busy      (busy),
        .parityErr (parityErr),
        .frameErr  (frameErr),
        .overflow  (overflow),
        .errCount  (errCount)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic par_bit(input logic [7:0] d, input logic ok);
        return ok ? ~(^d) : ^d;
    endfunction

    function automatic logic [7:0] exp_errcount();
`ifdef PS2_RX_ERRCOUNT_EN
        return exp_cnt[7:0];
`else
        return 8'h00;
`endif
    endfunction

    task automatic model_err();
        if (exp_cnt < 255) exp_cnt++;
    endtask

    // One frame's outcome by the protocol rules: stop, then parity, then FIFO room.
    task automatic model_frame(input logic [7:0] d, input logic par_ok,
                               input logic stop_ok, input logic pop_same);
        if (!stop_ok) begin
            exp_ferr = 1'b1; model_err();
        end else if (!par_ok) begin
            exp_perr = 1'b1; model_err();
        end else begin
            if (pop_same && exp_q.size() > 0) void'(exp_q.pop_front());
            if (exp_q.size() < DEPTH) exp_q.push_back(d);
            else begin exp_ovf = 1'b1; model_err(); end
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_perr = 0; exp_ferr = 0; exp_ovf = 0; exp_cnt = 0;
    endtask

    task automatic send_bit(input logic b);
        ps2Data = b;
        repeat (H) tick();
        ps2Clk = 1'b0;
        repeat (H) tick();
        ps2Clk = 1'b1;
    endtask

    task automatic send_head(input logic [7:0] d, input logic par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par);
    endtask

    // Falling edge is acted on at the third rising clk edge after the drop.
    task automatic send_stop(input logic stop, input logic pop_same);
        ps2Data = stop;
        repeat (H) tick();
        ps2Clk = 1'b0;
        repeat (2) tick();
        if (pop_same) rxRead = 1'b1;
        tick();
        rxRead = 1'b0;
        repeat (H - 3) tick();
        ps2Clk = 1'b1;
        repeat (H) tick();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_ok,
                              input logic stop_ok, input logic pop_same);
        send_head(d, par_bit(d, par_ok));
        send_stop(stop_ok, pop_same);
        model_frame(d, par_ok, stop_ok, pop_same);
    endtask

    task automatic read_one(output logic [7:0] v);
        v = rxData;
        rxRead = 1'b1;
        tick();
        rxRead = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
    endtask

    task automatic clear_err();
        clearErr = 1'b1;
        tick();
        clearErr = 1'b0;
        exp_perr = 0; exp_ferr = 0; exp_ovf = 0; exp_cnt = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1; ps2Clk = 1'b1; ps2Data = 1'b1; rxRead = 1'b0; clearErr = 1'b0;
        model_reset();
        repeat (3) tick();
        checks++;
        if ({rxValid, busy, parityErr, frameErr, overflow} !== 5'b0 ||
            rxData !== 8'h00 || errCount !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b b=%b pe=%b fe=%b ov=%b d=%h ec=%h required all zero",
                     rxValid, busy, parityErr, frameErr, overflow, rxData, errCount);
        end
        reset = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_good_frame();
        logic [7:0] v;
        send_head(8'h1C, 1'b0);
        ps2Data = 1'b1;
        repeat (H) tick();
        ps2Clk = 1'b0;
        repeat (2) tick();
        checks++;
        if (rxValid !== 1'b0) begin
            errors++; $display("FAIL good_early_valid: got %b required 0", rxValid);
        end
        tick();
        model_frame(8'h1C, 1'b1, 1'b1, 1'b0);
        checks++;
        if (rxValid !== 1'b1 || rxData !== 8'h1C) begin
            errors++; $display("FAIL good_valid: got v=%b d=%h required v=1 d=1c", rxValid, rxData);
        end
        repeat (H - 3) tick();
        ps2Clk = 1'b1;
        repeat (H) tick();
        read_one(v);
        checks++;
        if (rxValid !== 1'b0 || {parityErr, frameErr, overflow} !== 3'b0) begin
            errors++;
            $display("FAIL good_after_read: got v=%b flags=%b%b%b required v=0 flags=000",
                     rxValid, parityErr, frameErr, overflow);
        end
    endtask

    task automatic test_parity_err();
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        checks++;
        if (parityErr !== 1'b1 || rxValid !== 1'b0 || frameErr !== 1'b0) begin
            errors++;
            $display("FAIL parity_set: got pe=%b v=%b fe=%b required pe=1 v=0 fe=0",
                     parityErr, rxValid, frameErr);
        end
        checks++;
        if (errCount !== exp_errcount()) begin
            errors++; $display("FAIL parity_errcount: got %h required %h", errCount, exp_errcount());
        end
        clear_err();
        checks++;
        if (parityErr !== 1'b0 || errCount !== 8'h00) begin
            errors++; $display("FAIL parity_clear: got pe=%b ec=%h required pe=0 ec=00", parityErr, errCount);
        end
    endtask

    task automatic test_timeout();
        logic [7:0] v;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)));
        repeat (TO - 20) tick();
        checks++;
        if (busy !== 1'b1 || frameErr !== 1'b0) begin
            errors++; $display("FAIL timeout_early: got b=%b fe=%b required b=1 fe=0", busy, frameErr);
        end
        repeat (30) tick();
        exp_ferr = 1'b1; model_err();
        checks++;
        if (busy !== 1'b0 || frameErr !== 1'b1 || rxValid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_abort: got b=%b fe=%b v=%b required b=0 fe=1 v=0", busy, frameErr, rxValid);
        end
        send_frame(8'hF0, 1'b1, 1'b1, 1'b0);
        checks++;
        if (rxValid !== 1'b1 || rxData !== 8'hF0) begin
            errors++; $display("FAIL timeout_recover: got v=%b d=%h required v=1 d=f0", rxValid, rxData);
        end
        read_one(v);
        clear_err();
    endtask

    task automatic test_overflow();
        logic [7:0] v;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b1, 1'b0);
        checks++;
        if (overflow !== 1'b1 || errCount !== exp_errcount()) begin
            errors++;
            $display("FAIL overflow_set: got ov=%b ec=%h required ov=1 ec=%h", overflow, errCount, exp_errcount());
        end
        for (int i = 1; i <= 4; i++) begin
            read_one(v);
            checks++;
            if (v !== 8'(i)) begin
                errors++; $display("FAIL overflow_read%0d: got %h required %h", i, v, 8'(i));
            end
        end
        checks++;
        if (rxValid !== 1'b0) begin
            errors++; $display("FAIL overflow_drained: got v=%b required 0", rxValid);
        end
        clear_err();
    endtask

    task automatic test_full_pop();
        logic [7:0] v;
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 1'b1, 1'b0);
        send_frame(8'h05, 1'b1, 1'b1, 1'b1);
        checks++;
        if (overflow !== 1'b0 || rxValid !== 1'b1) begin
            errors++; $display("FAIL fullpop_no_ovf: got ov=%b v=%b required ov=0 v=1", overflow, rxValid);
        end
        for (int i = 2; i <= 5; i++) begin
            read_one(v);
            checks++;
            if (v !== 8'(i)) begin
                errors++; $display("FAIL fullpop_read%0d: got %h required %h", i, v, 8'(i));
            end
        end
        checks++;
        if (rxValid !== 1'b0) begin
            errors++; $display("FAIL fullpop_drained: got v=%b required 0", rxValid);
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] v;
        send_frame(8'($urandom), 1'b1, 1'b1, 1'b0);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
        reset = 1'b1;
        tick();
        model_reset();
        checks++;
        if (busy !== 1'b0 || rxValid !== 1'b0 || rxData !== 8'h00) begin
            errors++; $display("FAIL midreset: got b=%b v=%b d=%h required 0 0 00", busy, rxValid, rxData);
        end
        reset = 1'b0;
        repeat (2) tick();
        send_frame(8'h5A, 1'b1, 1'b1, 1'b0);
        checks++;
        if (rxValid !== 1'b1 || rxData !== 8'h5A ||
            {parityErr, frameErr, overflow} !== 3'b0) begin
            errors++;
            $display("FAIL midreset_frame: got v=%b d=%h flags=%b%b%b required v=1 d=5a flags=000",
                     rxValid, rxData, parityErr, frameErr, overflow);
        end
        read_one(v);
    endtask

    task automatic test_random();
        logic [7:0] d, v, want;
        int         kind;
        for (int n = 0; n < 40; n++) begin
            d    = 8'($urandom);
            kind = $urandom_range(0, 9);
            send_frame(d, kind != 0, kind != 1, 1'b0);
            checks++;
            if (rxValid !== (exp_q.size() > 0) || parityErr !== exp_perr ||
                frameErr !== exp_ferr || overflow !== exp_ovf || errCount !== exp_errcount() ||
                (exp_q.size() > 0 && rxData !== exp_q[0])) begin
                errors++;
                $display("FAIL rand_frame%0d: got v=%b d=%h pe=%b fe=%b ov=%b ec=%h required v=%b d=%h pe=%b fe=%b ov=%b ec=%h",
                         n, rxValid, rxData, parityErr, frameErr, overflow, errCount,
                         exp_q.size() > 0, exp_q.size() > 0 ? exp_q[0] : 8'h00,
                         exp_perr, exp_ferr, exp_ovf, exp_errcount());
            end
            for (int r = $urandom_range(0, 2); r > 0 && exp_q.size() > 0; r--) begin
                want = exp_q[0];
                read_one(v);
                checks++;
                if (v !== want) begin
                    errors++; $display("FAIL rand_read%0d: got %h required %h", n, v, want);
                end
            end
            if ($urandom_range(0, 4) == 0) clear_err();
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_parity_err();
        test_timeout();
        test_overflow();
        test_full_pop();
        test_reset_midframe();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ps2_rx_ctrl.md
Name: ps2_rx_ctrl

Overview:
- Receive-side controller for the debounced PS/2 clock/data pair feeding the SoC.
- Synchronises both lines into the CPU clock domain and sequences the 11-bit PS/2 frame: start, 8 data bits LSB first, odd parity, stop.
- Checks each frame, queues good scancodes in a small FIFO, and presents them to the CPU-side peripheral with a valid/read handshake plus sticky error flags.

Parameters:
- FIFO_DEPTH, 4, scancode entries; power of 2, minimum 2.
- TIMEOUT_CYCLES, 20000, clk cycles without a ps2Clk falling edge before an in-progress frame is aborted.

Ports:
- clk  input  1  system clock (SoC clock).
- reset  input  1  asynchronous, active-high reset.
- ps2Clk  input  1  debounced PS/2 clock; asynchronous to clk.
- ps2Data  input  1  debounced PS/2 data; asynchronous to clk.
- rxRead  input  1  pop head entry; ignored when rxValid=0.
- clearErr  input  1  clears parityErr, frameErr and overflow.
- rxData  output  8  FIFO head scancode.
- rxValid  output  1  FIFO not empty.
- busy  output  1  frame in progress (state != IDLE).
- parityErr  output  1  sticky: frame rejected for bad parity.
- frameErr  output  1  sticky: bad stop bit or timeout.
- overflow  output  1  sticky: good byte dropped because FIFO full.
- errCount  output  8  saturating error count (see Optional Feature).

Behaviour:
- Reset (async, active-high):
  - State IDLE; FIFO empty.
  - All outputs 0: rxData=0x00, rxValid=0, busy=0, all flags 0, errCount=0.
  - Synchroniser flops preset to 1 (idle bus level).
- Synchronisation and edge detection:
  - ps2Clk and ps2Data each pass through 2 flops, then a third "previous" flop on clk.
  - fall = prev & ~sync on clk.
  - Data is sampled from the synchronised ps2Data in the same cycle fall is detected.
- States: IDLE, DATA, PARITY, STOP. All transitions occur only on fall, except timeout.
  - IDLE: on fall with data=0 → DATA, bitCnt=0, timer=0. On fall with data=1 → stay IDLE (spurious edge, no flag).
  - DATA: shift data into shiftReg[7] (right shift, LSB first), bitCnt++. When bitCnt=7 → PARITY.
  - PARITY: latch parity bit → STOP.
  - STOP:
    - stop=1 and ^{shiftReg,parity}=1 → push shiftReg.
    - stop=0 → frameErr=1, no push.
    - stop=1 with bad parity → parityErr=1, no push.
    - If both stop=0 and bad parity: frameErr only.
    - Always → IDLE.
- Timeout:
  - Timer clears on every fall and counts while state != IDLE.
  - When timer = TIMEOUT_CYCLES-1: → IDLE, frameErr=1, partial byte discarded.
  - Timer holds at 0 while in IDLE.
- FIFO:
  - Push happens in the STOP-edge cycle; rxValid/rxData update on the next clk edge.
  - rxData is registered and always equals the head entry.
  - rxRead with rxValid=1 pops; new head visible the next cycle.
  - Push when full without a simultaneous pop: byte dropped, overflow=1.
  - Push and pop in the same cycle when full: both succeed, count unchanged, no overflow.
  - Pointers wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.
- Sticky flags:
  - Set events take priority over clearErr in the same cycle.
  - clearErr does not touch the FIFO or the state machine.
- busy = (state != IDLE).

Optional Feature:
- Macro: PS2_RX_ERRCOUNT_EN.
- Defined: errCount increments by 1 on each parityErr, frameErr or overflow set event. It saturates at 0xFF and is cleared by clearErr; a set event in the same cycle as clearErr yields 1.
- Undefined: errCount tied to 0x00; no counter flops synthesised.

Decomposition:
- Package ps2_pkg:
  - State encoding constants: IDLE=2'd0, DATA=2'd1, PARITY=2'd2, STOP=2'd3.
  - PS2_DATA_BITS=8.
  - Idle line level constant.
- Sub-module ps2_rx_fifo: synchronous FIFO with registered head output and full/empty. Parameter FIFO_DEPTH; ports clk, reset, push, din, pop, dout, empty, full.

Test Plan:
- Good frame 0x1C (data 0,0,1,1,1,0,0,0 LSB first; parity 0; stop 1) → rxValid=1 and rxData=0x1C one cycle after the stop edge; rxRead → rxValid=0; no flags.
- Frame 0x1C with parity bit 1 → parityErr=1, rxValid stays 0; clearErr → parityErr=0; with PS2_RX_ERRCOUNT_EN, errCount 1 → 0.
- Start plus 3 data bits, then ps2Clk held high for TIMEOUT_CYCLES → frameErr=1, busy=0. Following good frame 0xF0 (parity 1) → rxData=0xF0.
- Five good frames 0x01..0x05 with no reads, FIFO_DEPTH=4 → overflow=1; four reads return 0x01..0x04, then rxValid=0.
- FIFO full, rxRead asserted in the exact cycle frame 0x05 completes → no overflow; subsequent reads return 0x02,0x03,0x04,0x05.
- Assert reset after the 4th data bit; release; send good frame 0x5A → rxData=0x5A, no flags, no stale bits from the aborted frame.
